// File: rtl/alu_control_mc.sv
// Registered ALU control decoder at the ID/EX boundary.
// Sequences multi-cycle MULT/DIV and requests a pipeline stall while they run.
module alu_control_mc #(
  parameter int OP_WIDTH    = 4,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_WIDTH   = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          ALUOp,
  input  logic [5:0]          ALUFunction,
  input  logic                valid_in,
  input  logic                stall_in,
  input  logic                flush,
  output logic [OP_WIDTH-1:0] ALUOperation,
  output logic                valid_out,
  output logic                shamt_sel,
  output logic                jr_sel,
  output logic                stall_req,
  output logic                mc_done
);

  typedef enum logic [1:0] {
    IDLE,
    MC_RUN,
    MC_DONE
  } state_e;

  localparam logic [OP_WIDTH-1:0] OP_NOP = OP_WIDTH'(15);
  localparam logic [CNT_WIDTH-1:0] MUL_LD = CNT_WIDTH'(MULT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DIV_LD = CNT_WIDTH'(DIV_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [OP_WIDTH-1:0]  op_q, op_d;
  logic                 valid_q, valid_d;
  logic                 sh_q, sh_d;
  logic                 jr_q, jr_d;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                 is_r;
  logic [3:0]           dec_op;
  logic                 dec_sh;
  logic                 dec_jr;
  logic                 dec_mul;
  logic                 dec_div;
  logic [CNT_WIDTH-1:0] dec_ld;

  assign is_r = (ALUOp == 4'b0111);

  always_comb begin
    dec_op = 4'd15;
    unique case (1'b1)
      is_r && ALUFunction == 6'b100100: dec_op = 4'd0;
      is_r && ALUFunction == 6'b100101: dec_op = 4'd1;
      is_r && ALUFunction == 6'b100111: dec_op = 4'd2;
      is_r && ALUFunction == 6'b100000: dec_op = 4'd3;
      is_r && ALUFunction == 6'b100010: dec_op = 4'd4;
      is_r && ALUFunction == 6'b000000: dec_op = 4'd5;
      is_r && ALUFunction == 6'b000010: dec_op = 4'd6;
      is_r && ALUFunction == 6'b000011: dec_op = 4'd8;
      is_r && ALUFunction == 6'b011000: dec_op = 4'd13;
      is_r && ALUFunction == 6'b011010: dec_op = 4'd14;
      is_r && ALUFunction == 6'b001000: dec_op = 4'd10;
      ALUOp == 4'b0100:                 dec_op = 4'd3;
      ALUOp == 4'b0101:                 dec_op = 4'd1;
      ALUOp == 4'b0010:                 dec_op = 4'd7;
      ALUOp == 4'b0011:                 dec_op = 4'd0;
      ALUOp == 4'b0001:                 dec_op = 4'd4;
      ALUOp == 4'b0110:                 dec_op = 4'd9;
      ALUOp == 4'b1000:                 dec_op = 4'd11;
      ALUOp == 4'b1001:                 dec_op = 4'd12;
      default:                          dec_op = 4'd15;
    endcase
  end

  assign dec_sh  = (dec_op == 4'd5) || (dec_op == 4'd6) || (dec_op == 4'd8);
  assign dec_jr  = (dec_op == 4'd10);
  assign dec_mul = (dec_op == 4'd13);
  assign dec_div = (dec_op == 4'd14);
  assign dec_ld  = dec_mul ? MUL_LD : DIV_LD;

  assign stall_req = (state_q == MC_RUN);
  assign mc_done   = (state_q == MC_DONE);

  always_comb begin
    op_d    = op_q;
    valid_d = valid_q;
    sh_d    = sh_q;
    jr_d    = jr_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      op_d    = OP_NOP;
      valid_d = 1'b0;
      sh_d    = 1'b0;
      jr_d    = 1'b0;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      // A running op keeps counting even under an external stall.
      if (state_q == MC_RUN) begin
        if (cnt_q <= CNT_ONE) begin
          cnt_d   = '0;
          state_d = MC_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end else if (state_q == MC_DONE) begin
        state_d = IDLE;
      end
      if (!stall_in && !stall_req) begin
        op_d    = OP_WIDTH'(dec_op);
        valid_d = valid_in;
        sh_d    = dec_sh;
        jr_d    = dec_jr;
        if (valid_in && (dec_mul || dec_div)) begin
          cnt_d   = dec_ld;
          state_d = (dec_ld == '0) ? MC_DONE : MC_RUN;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= OP_NOP;
      valid_q <= 1'b0;
      sh_q    <= 1'b0;
      jr_q    <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      op_q    <= op_d;
      valid_q <= valid_d;
      sh_q    <= sh_d;
      jr_q    <= jr_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ALUOperation = op_q;
  assign valid_out    = valid_q;
  assign shamt_sel    = sh_q;
  assign jr_sel       = jr_q;

endmodule

// File: tb/tb_alu_control_mc.sv
// Randomized and directed checks of alu_control_mc against an
// occupancy-count reference model, on two parameter sets.
module tb_alu_control_mc;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ALUOp;
  logic [5:0] ALUFunction;
  logic       valid_in, stall_in, flush;

  logic [3:0] op0, op1;
  logic v0, v1, sh0, sh1, jr0, jr1, sr0, sr1, md0, md1;

  always #5 clk = ~clk;

  alu_control_mc dut0 (
    .clk(clk), .reset(reset), .ALUOp(ALUOp), .ALUFunction(ALUFunction),
    .valid_in(valid_in), .stall_in(stall_in), .flush(flush),
    .ALUOperation(op0), .valid_out(v0), .shamt_sel(sh0), .jr_sel(jr0),
    .stall_req(sr0), .mc_done(md0)
  );

  alu_control_mc #(.MULT_CYCLES(1), .DIV_CYCLES(2)) dut1 (
    .clk(clk), .reset(reset), .ALUOp(ALUOp), .ALUFunction(ALUFunction),
    .valid_in(valid_in), .stall_in(stall_in), .flush(flush),
    .ALUOperation(op1), .valid_out(v1), .shamt_sel(sh1), .jr_sel(jr1),
    .stall_req(sr1), .mc_done(md1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0] a;
    logic [5:0] f;
    int         e;
  } ent_t;

  ent_t tbl [21] = '{
    '{4'b0111, 6'b100100, 0},  '{4'b0111, 6'b100101, 1},
    '{4'b0111, 6'b100111, 2},  '{4'b0111, 6'b100000, 3},
    '{4'b0111, 6'b100010, 4},  '{4'b0111, 6'b000000, 5},
    '{4'b0111, 6'b000010, 6},  '{4'b0111, 6'b000011, 8},
    '{4'b0111, 6'b011000, 13}, '{4'b0111, 6'b011010, 14},
    '{4'b0111, 6'b001000, 10}, '{4'b0100, 6'b000000, 3},
    '{4'b0101, 6'b000000, 1},  '{4'b0010, 6'b000000, 7},
    '{4'b0011, 6'b000000, 0},  '{4'b0001, 6'b000000, 4},
    '{4'b0110, 6'b000000, 9},  '{4'b1000, 6'b000000, 11},
    '{4'b1001, 6'b000000, 12}, '{4'b0111, 6'b111111, 15},
    '{4'b1111, 6'b000000, 15}
  };

  // Model: m_rem = EX cycles still owned by the current multi-cycle op.
  int NM [2] = '{4, 1};
  int ND [2] = '{32, 2};
  int m_op [2];
  int m_rem [2];
  bit m_v [2], m_sh [2], m_jr [2];

  function automatic int ref_dec(input logic [3:0] a, input logic [5:0] f);
    if (a == 4'b0111) begin
      case (f)
        6'b100100: return 0;
        6'b100101: return 1;
        6'b100111: return 2;
        6'b100000: return 3;
        6'b100010: return 4;
        6'b000000: return 5;
        6'b000010: return 6;
        6'b000011: return 8;
        6'b011000: return 13;
        6'b011010: return 14;
        6'b001000: return 10;
        default:   return 15;
      endcase
    end
    case (a)
      4'b0100: return 3;
      4'b0101: return 1;
      4'b0010: return 7;
      4'b0011: return 0;
      4'b0001: return 4;
      4'b0110: return 9;
      4'b1000: return 11;
      4'b1001: return 12;
      default: return 15;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_op[i] = 15; m_v[i] = 0; m_sh[i] = 0; m_jr[i] = 0; m_rem[i] = 0;
    end
  endtask

  task automatic model_edge();
    int d;
    d = ref_dec(ALUOp, ALUFunction);
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_op[i] = 15; m_v[i] = 0; m_sh[i] = 0; m_jr[i] = 0; m_rem[i] = 0;
      end else if (flush) begin
        m_op[i] = 15; m_v[i] = 0; m_sh[i] = 0; m_jr[i] = 0; m_rem[i] = 0;
      end else if (stall_in || m_rem[i] > 1) begin
        if (m_rem[i] > 0) m_rem[i]--;
      end else begin
        m_op[i] = d;
        m_v[i]  = valid_in;
        m_sh[i] = (d == 5 || d == 6 || d == 8);
        m_jr[i] = (d == 10);
        if (valid_in && d == 13) m_rem[i] = NM[i];
        else if (valid_in && d == 14) m_rem[i] = ND[i];
        else m_rem[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("op0", op0, m_op[0]);
    chk("valid0", v0, m_v[0]);
    chk("shamt0", sh0, m_sh[0]);
    chk("jr0", jr0, m_jr[0]);
    chk("stall_req0", sr0, m_rem[0] > 1);
    chk("mc_done0", md0, m_rem[0] == 1);
    chk("op1", op1, m_op[1]);
    chk("valid1", v1, m_v[1]);
    chk("shamt1", sh1, m_sh[1]);
    chk("jr1", jr1, m_jr[1]);
    chk("stall_req1", sr1, m_rem[1] > 1);
    chk("mc_done1", md1, m_rem[1] == 1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic [3:0] a, input logic [5:0] f,
                       input logic v, input logic s, input logic fl);
    ALUOp = a; ALUFunction = f; valid_in = v; stall_in = s; flush = fl;
  endtask

  task automatic drain();
    drive(4'b0000, 6'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 40 && (m_rem[0] != 0 || m_rem[1] != 0); k++) tick();
    chk("drain", {sr0, sr1, md0, md1}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nstall, done_at, npulse, idx;
    logic [3:0] ra;
    logic [5:0] rf;

    model_reset();
    reset = 1'b0;
    repeat (3) begin
      drive(4'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    chk("rst_op", op0, 15);
    chk("rst_valid", v0, 0);
    chk("rst_stall", sr0, 0);
    reset = 1'b1;

    drive(4'b0111, 6'b100000, 1'b1, 1'b0, 1'b0);
    tick();
    chk("add_op", op0, 3);
    chk("add_valid", v0, 1);

    for (int i = 0; i < 21; i++) begin
      rf = (tbl[i].a == 4'b0111) ? tbl[i].f : 6'($urandom);
      drive(tbl[i].a, rf, 1'b1, 1'b0, 1'b0);
      tick();
      chk("sweep_op", op0, tbl[i].e);
      if (tbl[i].e == 5 || tbl[i].e == 6 || tbl[i].e == 8)
        chk("sweep_shamt", sh0, 1);
      if (tbl[i].e == 10) chk("sweep_jr", jr0, 1);
      drain();
    end

    drive(4'b0111, 6'b011000, 1'b1, 1'b0, 1'b0);
    tick();
    chk("mul_op", op0, 13);
    nstall = sr0;
    npulse = md0;
    done_at = md0 ? 0 : -1;
    drive(4'b0101, 6'b110011, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      nstall += sr0;
      npulse += md0;
      if (md0 && done_at < 0) done_at = k;
      if (k == 3) chk("mul_op_at_done", op0, 13);
      if (k == 4) chk("ori_after_mul", op0, 1);
    end
    chk("mul_stall_cycles", nstall, 3);
    chk("mul_done_at", done_at, 3);
    chk("mul_done_pulses", npulse, 1);
    drain();

    drive(4'b0111, 6'b011010, 1'b1, 1'b0, 1'b0);
    tick();
    nstall = sr0;
    drive(4'b0111, 6'b100000, 1'b1, 1'b0, 1'b0);
    repeat (9) begin
      tick();
      nstall += sr0;
    end
    chk("div_stall_pre_flush", nstall, 10);
    drive(4'b0111, 6'b100000, 1'b1, 1'b0, 1'b1);
    tick();
    chk("div_flush_stall", sr0, 0);
    chk("div_flush_done", md0, 0);
    chk("div_flush_op", op0, 15);
    chk("div_flush_valid", v0, 0);
    drive(4'b0000, 6'b0, 1'b0, 1'b0, 1'b0);
    npulse = 0;
    repeat (25) begin
      tick();
      npulse += md0;
    end
    chk("div_no_done", npulse, 0);

    drive(4'b0111, 6'b100010, 1'b1, 1'b1, 1'b1);
    tick();
    chk("flush_wins_valid", v0, 0);
    chk("flush_wins_op", op0, 15);
    drive(4'b0111, 6'b100000, 1'b1, 1'b0, 1'b0);
    tick();
    chk("pre_hold_op", op0, 3);
    drive(4'b0111, 6'b100010, 1'b1, 1'b1, 1'b0);
    repeat (3) begin
      tick();
      chk("hold_op", op0, 3);
      chk("hold_valid", v0, 1);
    end
    drain();

    drive(4'b0111, 6'b011000, 1'b1, 1'b0, 1'b0);
    tick();
    chk("b2b_done1", md1, 1);
    chk("b2b_stall1", sr1, 0);
    tick();
    chk("b2b_done2", md1, 1);
    chk("b2b_stall2", sr1, 0);
    drain();

    drive(4'b0111, 6'b011010, 1'b1, 1'b0, 1'b0);
    tick();
    drive(4'b0000, 6'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_rst_stall", sr0, 0);
    @(negedge clk);
    reset = 1'b1;

    repeat (600) begin
      idx = $urandom_range(0, 20);
      ra = tbl[idx].a;
      rf = (ra == 4'b0111) ? tbl[idx].f : 6'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        ra = 4'($urandom);
        rf = 6'($urandom);
      end
      drive(ra, rf, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 99) != 0);
      tick();
      reset = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_control_mc.md
Name: alu_control_mc

Overview:
- Parametrised, registered successor to the combinational ALU control decoder.
- Sits at the ID/EX boundary. Decodes {ALUOp, ALUFunction} into an ALU operation code and registers it into EX alongside a valid bit.
- Adds multi-cycle MULT/DIV sequencing with a pipeline stall request, plus flush and stall handling for the hazard unit.

Parameters:
- OP_WIDTH, 4, width of ALUOperation. Must be >= 4; codes are zero-extended.
- MULT_CYCLES, 4, EX occupancy of MULT in cycles. Must be >= 1.
- DIV_CYCLES, 32, EX occupancy of DIV in cycles. Must be >= 1.
- CNT_WIDTH, 6, cycle counter width. Must hold max(MULT_CYCLES, DIV_CYCLES) - 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ALUOp  input  4  from main control unit.
- ALUFunction  input  6  instruction funct field.
- valid_in  input  1  ID stage holds a valid instruction.
- stall_in  input  1  hazard unit stall; hold EX register.
- flush  input  1  kill the instruction entering EX.
- ALUOperation  output  OP_WIDTH  registered ALU operation code.
- valid_out  output  1  ALUOperation is valid in EX.
- shamt_sel  output  1  registered; 1 for SLL/SRL/SRA (ALU B operand = shamt).
- jr_sel  output  1  registered; 1 for JR.
- stall_req  output  1  combinational; 1 while a multi-cycle op is running.
- mc_done  output  1  one-cycle pulse when a MULT/DIV completes.

Behaviour:
- Reset (reset=0, asynchronous) drives these values:
  - ALUOperation = 15, valid_out = 0, shamt_sel = 0, jr_sel = 0.
  - State = IDLE, counter = 0, stall_req = 0, mc_done = 0.
- Decode table, keyed on ALUOp_funct. Entries with funct "x" match on ALUOp alone:
  - 0111_100100 AND -> 0.
  - 0111_100101 OR -> 1.
  - 0111_100111 NOR -> 2.
  - 0111_100000 ADD -> 3.
  - 0111_100010 SUB -> 4.
  - 0111_000000 SLL -> 5.
  - 0111_000010 SRL -> 6.
  - 0111_000011 SRA -> 8 (new).
  - 0111_011000 MULT -> 13 (new).
  - 0111_011010 DIV -> 14 (new).
  - 0111_001000 JR -> 10.
  - 0100_x ADDI -> 3.
  - 0101_x ORI -> 1.
  - 0010_x LUI -> 7.
  - 0011_x ANDI -> 0.
  - 0001_x BEQ/BNE -> 4.
  - 0110_x JAL -> 9.
  - 1000_x LW -> 11.
  - 1001_x SW -> 12.
  - Anything else -> 15.
- Latency: 1 cycle. Decode is combinational; outputs are registered on the rising clk edge.
- Per-edge update priority:
  1. flush=1: valid_out <= 0, ALUOperation <= 15, shamt_sel <= 0, jr_sel <= 0. A running MULT/DIV is aborted (state -> IDLE) with no mc_done. Flush beats stall_in and stall_req.
  2. Otherwise, if stall_in=1 or stall_req=1: all registered outputs hold.
  3. Otherwise: register the decode results, and valid_out <= valid_in.
- When valid_in=0 the decode is still registered, but valid_out=0 and no MULT/DIV is started.
- FSM states: IDLE, MC_RUN, MC_DONE.
- IDLE -> MC_RUN: on an accepted valid MULT or DIV (case 3 above with valid_in=1). The counter is loaded with MULT_CYCLES-1 or DIV_CYCLES-1.
  - Exception: if the loaded value is 0, go directly to MC_DONE.
- MC_RUN:
  - stall_req = 1; counter decrements each cycle.
  - counter==1 -> counter 0, next state MC_DONE.
- MC_DONE:
  - mc_done = 1, stall_req = 0; the pipeline advances this cycle.
  - Next state: IDLE.
  - A MULT/DIV accepted in MC_DONE starts a new run (back-to-back allowed).
- Total stall_req cycles = N-1 for N-cycle ops. The op occupies EX for exactly N cycles including the MC_DONE cycle.
- While stall_req=1, changes on ALUOp/ALUFunction/valid_in are ignored.
- stall_in asserted during MC_RUN: the counter continues; a multi-cycle op is not frozen by an external stall.
- stall_in asserted during MC_DONE: mc_done still pulses once; state still returns to IDLE.
- Reset mid-run: returns to IDLE immediately, asynchronously.
- Counter never underflows. In IDLE the counter holds 0.

Test Plan:
- Reset: hold reset=0 with random inputs -> ALUOperation=15, valid_out=0, stall_req=0. After release, ADD (0111_100000, valid_in=1) -> next edge ALUOperation=3, valid_out=1.
- Full decode sweep: every table entry plus 0111_111111 and 1111_000000. Each is checked one cycle later; the two unlisted codes give 15. SLL/SRL/SRA give shamt_sel=1; JR gives jr_sel=1.
- MULT with MULT_CYCLES=4:
  - stall_req high exactly 3 cycles; mc_done one pulse on the 4th cycle.
  - An ORI presented during the stall registers only after mc_done: ALUOperation 13 then 1.
- DIV with DIV_CYCLES=32: stall_req high 31 cycles. A flush at cycle 10 -> state IDLE, stall_req=0, no mc_done, ALUOperation=15, valid_out=0.
- Simultaneous flush=1 and stall_in=1 with SUB presented -> flush wins: valid_out=0, ALUOperation=15.
  - Then stall_in=1 alone -> outputs hold for 3 cycles.
- Back-to-back MULT, MULT with MULT_CYCLES=1 -> no stall_req, mc_done pulses on two consecutive cycles.
